// File: rtl/cnn_top.sv
// Binary-image 3x3 convolution (parameterised weights and bias) followed by
// 2x2 stride-2 max pooling on a 28x28 raster stream. Optional macro CNN_RELU_EN clamps conv results at zero.
module cnn_top #(
  parameter logic signed [7:0]  W0   = 8'sd1,
  parameter logic signed [7:0]  W1   = 8'sd1,
  parameter logic signed [7:0]  W2   = 8'sd1,
  parameter logic signed [7:0]  W3   = 8'sd1,
  parameter logic signed [7:0]  W4   = 8'sd1,
  parameter logic signed [7:0]  W5   = 8'sd1,
  parameter logic signed [7:0]  W6   = 8'sd1,
  parameter logic signed [7:0]  W7   = 8'sd1,
  parameter logic signed [7:0]  W8   = 8'sd1,
  parameter logic signed [31:0] BIAS = 32'sd0
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        bin_data_vld,
  input  logic        bin_data,
  output logic [31:0] pool_data,
  output logic        pool_data_vld,
  output logic        active_video,
  output logic        vid_hsync,
  output logic        vid_ce
);

  localparam logic [4:0]  LAST_IDX = 5'd27;
  localparam logic [71:0] WVEC     = {W8, W7, W6, W5, W4, W3, W2, W1, W0};

  function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [4:0]  col_r;
  logic [4:0]  row_r;
  logic [27:0] lb1_r;
  logic [27:0] lb2_r;
  logic [2:0]  win_c0_r;
  logic [2:0]  win_c1_r;
  logic [2:0]  new_col_s;
  logic [8:0]  pix_s;
  logic        conv_en_s;

  // Column entering the window: bit0 = row r-2, bit2 = current row.
  assign new_col_s = {bin_data, lb1_r[col_r], lb2_r[col_r]};
  assign pix_s     = {new_col_s[2], win_c1_r[2], win_c0_r[2],
                      new_col_s[1], win_c1_r[1], win_c0_r[1],
                      new_col_s[0], win_c1_r[0], win_c0_r[0]};
  assign conv_en_s = bin_data_vld && (row_r >= 5'd2) && (col_r >= 5'd2);

  // Pixel position counters and the two older window columns.
  always_ff @(posedge sclk or posedge s_rst_n) begin
    if (s_rst_n) begin
      col_r    <= 5'd0;
      row_r    <= 5'd0;
      win_c0_r <= 3'd0;
      win_c1_r <= 3'd0;
    end else if (bin_data_vld) begin
      win_c0_r <= win_c1_r;
      win_c1_r <= new_col_s;
      if (col_r == LAST_IDX) begin
        col_r <= 5'd0;
        row_r <= (row_r == LAST_IDX) ? 5'd0 : row_r + 5'd1;
      end else begin
        col_r <= col_r + 5'd1;
      end
    end
  end

  // Line buffers: rows 0..1 of every frame overwrite them before use.
  always_ff @(posedge sclk) begin
    if (bin_data_vld) begin
      lb2_r[col_r] <= lb1_r[col_r];
      lb1_r[col_r] <= bin_data;
    end
  end

  logic signed [31:0] conv_sum_s;
  logic signed [31:0] conv_rect_s;

  // Weighted sum of the window; only set pixels contribute.
  always_comb begin
    conv_sum_s = BIAS;
    for (int k = 0; k < 9; k++) begin
      if (pix_s[k]) begin
        conv_sum_s = conv_sum_s + $signed({{24{WVEC[8*k+7]}}, WVEC[8*k +: 8]});
      end else begin
        conv_sum_s = conv_sum_s;
      end
    end
  end

  // Optional rectification ahead of pooling.
  always_comb begin
`ifdef CNN_RELU_EN
    if (conv_sum_s[31]) begin
      conv_rect_s = 32'sd0;
    end else begin
      conv_rect_s = conv_sum_s;
    end
`else
    conv_rect_s = conv_sum_s;
`endif
  end

  logic               conv_vld_r;
  logic signed [31:0] conv_data_r;
  logic [4:0]         conv_row_r;
  logic [4:0]         conv_col_r;

  // Conv result register, tagged with its conv-map coordinates.
  always_ff @(posedge sclk or posedge s_rst_n) begin
    if (s_rst_n) begin
      conv_vld_r  <= 1'b0;
      conv_data_r <= 32'sd0;
      conv_row_r  <= 5'd0;
      conv_col_r  <= 5'd0;
    end else begin
      conv_vld_r <= conv_en_s;
      if (conv_en_s) begin
        conv_data_r <= conv_rect_s;
        conv_row_r  <= row_r - 5'd2;
        conv_col_r  <= col_r - 5'd2;
      end else begin
        conv_data_r <= conv_data_r;
        conv_row_r  <= conv_row_r;
        conv_col_r  <= conv_col_r;
      end
    end
  end

  logic signed [31:0] row_buf_r [26];
  logic signed [31:0] prev_col_r;

  // Even conv rows are parked whole; even columns wait in prev_col_r.
  always_ff @(posedge sclk) begin
    if (conv_vld_r && !conv_row_r[0]) begin
      row_buf_r[conv_col_r] <= conv_data_r;
    end
    if (conv_vld_r && !conv_col_r[0]) begin
      prev_col_r <= conv_data_r;
    end
  end

  logic               pool_emit_s;
  logic [3:0]         pool_j_s;
  logic signed [31:0] pool_max_s;
  logic               last_out_r;

  assign pool_emit_s = conv_vld_r && conv_row_r[0] && conv_col_r[0];
  assign pool_j_s    = conv_col_r[4:1];
  assign pool_max_s  = smax(smax(row_buf_r[conv_col_r - 5'd1], row_buf_r[conv_col_r]),
                            smax(prev_col_r, conv_data_r));

  // Pooled output, row framing and end-of-row pulse.
  always_ff @(posedge sclk or posedge s_rst_n) begin
    if (s_rst_n) begin
      pool_data     <= 32'd0;
      pool_data_vld <= 1'b0;
      active_video  <= 1'b0;
      vid_hsync     <= 1'b0;
      last_out_r    <= 1'b0;
    end else begin
      pool_data_vld <= pool_emit_s;
      pool_data     <= pool_emit_s ? pool_max_s : pool_data;
      last_out_r    <= pool_emit_s && (pool_j_s == 4'd12);
      vid_hsync     <= last_out_r;
      if (pool_emit_s && (pool_j_s == 4'd0)) begin
        active_video <= 1'b1;
      end else if (last_out_r) begin
        active_video <= 1'b0;
      end else begin
        active_video <= active_video;
      end
    end
  end

  assign vid_ce = pool_data_vld;

endmodule

// File: tb/tb_cnn_top.sv
// Self-checking bench for cnn_top: two instances (default and signed weights with BIAS=-5)
// compared against a software conv/pool model via expected-value queues.
module tb_cnn_top;

  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b1;
  logic        bin_data_vld = 1'b0;
  logic        bin_data = 1'b0;
  logic [31:0] pd_a, pd_b;
  logic        pv_a, pv_b, av_a, av_b, hs_a, hs_b, ce_a, ce_b;

  always #5 sclk = ~sclk;

  cnn_top dut_a (
    .sclk(sclk), .s_rst_n(s_rst_n), .bin_data_vld(bin_data_vld), .bin_data(bin_data),
    .pool_data(pd_a), .pool_data_vld(pv_a), .active_video(av_a), .vid_hsync(hs_a), .vid_ce(ce_a)
  );

  cnn_top #(
    .W0(8'sd5), .W1(-8'sd2), .W2(8'sd3), .W3(-8'sd7), .W4(-8'sd3),
    .W5(8'sd4), .W6(8'sd1), .W7(-8'sd1), .W8(8'sd2), .BIAS(-32'sd5)
  ) dut_b (
    .sclk(sclk), .s_rst_n(s_rst_n), .bin_data_vld(bin_data_vld), .bin_data(bin_data),
    .pool_data(pd_b), .pool_data_vld(pv_b), .active_video(av_b), .vid_hsync(hs_b), .vid_ce(ce_b)
  );

  localparam int WA[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  localparam int WB[9] = '{5, -2, 3, -7, -3, 4, 1, -1, 2};
  localparam int BA = 0;
  localparam int BB = -5;

  typedef struct {
    int pattern;    // 0 zeros, 1 ones, 2 single (3,3), 3 random, 4 checker
    int gap;        // idle cycles after each pixel, -1 = random 0..3
    int frames;     // back-to-back frames
    int abort_px;   // pixels of an aborted frame before reset, 0 = none
    int exp_outs;
    int exp_hsync;
  } vec_t;

  int tests = 0;
  int fails = 0;
  bit img [28][28];
  int qa[$];
  int qb[$];
  int last_a, last_b;
  int outs_a, outs_b, hcnt_a, hcnt_b;
  bit checking = 1'b0;
  int cur_r = -1, cur_c = -1;
  bit lat_armed = 1'b0;
  int lat_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int conv_at(input int which, input int cr, input int cc);
    int s = (which == 0) ? BA : BB;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        if (img[cr+kr][cc+kc]) s += (which == 0) ? WA[kr*3+kc] : WB[kr*3+kc];
`ifdef CNN_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic model_push();
    for (int i = 0; i < 13; i++)
      for (int j = 0; j < 13; j++) begin
        int ma = conv_at(0, 2*i, 2*j);
        int mb = conv_at(1, 2*i, 2*j);
        for (int d = 1; d < 4; d++) begin
          int va = conv_at(0, 2*i + d/2, 2*j + d%2);
          int vb = conv_at(1, 2*i + d/2, 2*j + d%2);
          if (va > ma) ma = va;
          if (vb > mb) mb = vb;
        end
        qa.push_back(ma);
        qb.push_back(mb);
        last_a = ma;
        last_b = mb;
      end
  endtask

  task automatic build_img(input int pattern);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        case (pattern)
          0: img[r][c] = 1'b0;
          1: img[r][c] = 1'b1;
          2: img[r][c] = (r == 3 && c == 3);
          3: img[r][c] = 1'($urandom_range(0, 1));
          default: img[r][c] = 1'((r + c) % 2);
        endcase
  endtask

  task automatic drive_pixels(input int count, input int gap);
    for (int p = 0; p < count; p++) begin
      int g = (gap < 0) ? $urandom_range(0, 3) : gap;
      cur_r = p / 28;
      cur_c = p % 28;
      bin_data = img[cur_r][cur_c];
      bin_data_vld = 1'b1;
      @(posedge sclk); #1;
      bin_data_vld = 1'b0;
      repeat (g) begin @(posedge sclk); #1; end
    end
    cur_r = -1;
    cur_c = -1;
  endtask

  task automatic reset_and_check(input string tag);
    s_rst_n = 1'b1;
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    check({tag, "_rst_pd_a"}, pd_a, 32'd0);
    check({tag, "_rst_pd_b"}, pd_b, 32'd0);
    check({tag, "_rst_flags_a"}, {28'd0, pv_a, av_a, hs_a, ce_a}, 32'd0);
    check({tag, "_rst_flags_b"}, {28'd0, pv_b, av_b, hs_b, ce_b}, 32'd0);
    @(posedge sclk); #1;
    s_rst_n = 1'b0;
  endtask

  // Scoreboard and framing monitor, sampled mid-cycle.
  always @(negedge sclk) begin
    if (checking) begin
      if (lat_armed) lat_cnt++;
      if (pv_a) begin
        outs_a++;
        if (lat_armed) begin
          check("latency", lat_cnt, 2);
          lat_armed = 1'b0;
        end
        if (qa.size() == 0) check("extra_out_a", 32'd1, 32'd0);
        else check("pool_a", pd_a, qa.pop_front());
        check("av_during_out_a", {31'd0, av_a}, 32'd1);
        check("ce_a", {31'd0, ce_a}, 32'd1);
      end
      if (pv_b) begin
        outs_b++;
        if (qb.size() == 0) check("extra_out_b", 32'd1, 32'd0);
        else check("pool_b", pd_b, qb.pop_front());
      end
      if (hs_a) begin
        hcnt_a++;
        check("av_low_at_hsync_a", {31'd0, av_a}, 32'd0);
      end
      if (hs_b) hcnt_b++;
      if (bin_data_vld && cur_r == 3 && cur_c == 3) begin
        lat_armed = 1'b1;
        lat_cnt = 0;
      end
    end
  end

  vec_t vecs [7];

  initial begin
    vecs[0] = '{0, 0, 1, 0, 169, 13};
    vecs[1] = '{1, 0, 1, 0, 169, 13};
    vecs[2] = '{2, 0, 1, 0, 169, 13};
    vecs[3] = '{1, 2, 1, 0, 169, 13};
    vecs[4] = '{3, 0, 2, 0, 338, 26};
    vecs[5] = '{4, -1, 1, 0, 169, 13};
    vecs[6] = '{1, 0, 1, 400, 169, 13};

    @(posedge sclk); #1;
    reset_and_check("init");

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].abort_px > 0) begin
        checking = 1'b0;
        build_img(vecs[v].pattern);
        drive_pixels(vecs[v].abort_px, vecs[v].gap);
        reset_and_check($sformatf("v%0d_abort", v));
      end
      qa.delete();
      qb.delete();
      outs_a = 0; outs_b = 0; hcnt_a = 0; hcnt_b = 0;
      lat_armed = 1'b0;
      checking = 1'b1;
      for (int f = 0; f < vecs[v].frames; f++) begin
        build_img(vecs[v].pattern);
        model_push();
        drive_pixels(784, vecs[v].gap);
      end
      repeat (6) @(posedge sclk);
      @(negedge sclk);
      check($sformatf("v%0d_outs_a", v), outs_a, vecs[v].exp_outs);
      check($sformatf("v%0d_outs_b", v), outs_b, vecs[v].exp_outs);
      check($sformatf("v%0d_hsync_a", v), hcnt_a, vecs[v].exp_hsync);
      check($sformatf("v%0d_hsync_b", v), hcnt_b, vecs[v].exp_hsync);
      check($sformatf("v%0d_left_a", v), qa.size(), 0);
      check($sformatf("v%0d_hold_a", v), pd_a, last_a);
      check($sformatf("v%0d_hold_b", v), pd_b, last_b);
      check($sformatf("v%0d_av_idle", v), {31'd0, av_a}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cnn_top.md
CNN_TOP -- requirements
Module: cnn_top

Interface
REQ-001 Parameters (name, default, meaning): W0..W8, 1, signed 8-bit 3x3 kernel weights in raster order (W0 top-left, W8 bottom-right).
REQ-002 BIAS, 0: signed 32-bit value added to every convolution sum.
REQ-003 sclk  input  1  single clock; all logic on its rising edge.
REQ-004 s_rst_n  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-005 bin_data_vld  input  1  qualifies bin_data; arbitrary gaps allowed.
REQ-006 bin_data  input  1  binarized pixel; 28x28 frame, raster order.
REQ-007 pool_data  output  32  signed max-pooled feature value.
REQ-008 pool_data_vld  output  1  one-cycle strobe per pool_data word.
REQ-009 active_video  output  1  high across each pooled output row.
REQ-010 vid_hsync  output  1  one-cycle end-of-pooled-row pulse.
REQ-011 vid_ce  output  1  pixel clock enable; equal to pool_data_vld.

Function
REQ-012 Column counter c (0..27) and row counter r (0..27) SHALL advance only on cycles with bin_data_vld=1.
- c wraps 27->0 and increments r.
- r wraps 27->0 after pixel 784.
- Frame boundaries are defined by pixel count alone; there is no sync input.
REQ-013 Two 28-bit line buffers SHALL provide a 3x3 window of rows r-2..r and columns c-2..c.
REQ-014 For each accepted pixel with r>=2 and c>=2, conv(r-2,c-2) = BIAS + sum of Wk over window pixels equal to 1, sign-extended to 32 bits.
- The result SHALL be registered one cycle after the accepting cycle.
- This yields a 26x26 conv map.
REQ-015 A 26-word conv row buffer plus a previous-column register SHALL support 2x2 stride-2 max pooling.
- pool(i,j) = signed max of conv(2i..2i+1, 2j..2j+1), for i,j in 0..12.
REQ-016 pool(i,j) SHALL be emitted with pool_data_vld=1 one cycle after conv(2i+1,2j+1) is valid.
- Total latency: 2 cycles from acceptance of pixel (2i+3, 2j+3).
- Exactly 169 outputs per frame, in raster order.
REQ-017 pool_data SHALL hold its last value when pool_data_vld=0.
REQ-018 active_video SHALL rise with the j=0 output of a pooled row and fall the cycle after the j=12 output.
REQ-019 vid_hsync SHALL pulse for one cycle, coincident with active_video falling: 13 pulses per frame.
REQ-020 There is no backpressure; input gaps only stretch timing and SHALL NOT change output values.
REQ-021 Consecutive frames SHALL process back-to-back with no idle cycles required.

Reset
REQ-022 While s_rst_n=1, the following SHALL be 0: counters, window registers, conv valid, pool_data, pool_data_vld, active_video, vid_hsync and vid_ce.
REQ-023 Line-buffer and conv-row-buffer contents need not be cleared. Rows 0..1 of any new frame fully overwrite them before use.
REQ-024 Reset mid-frame SHALL abort the frame. The next accepted pixel after release is pixel (0,0).

Configuration
REQ-025 Macro CNN_RELU_EN controls rectification of conv results.
- Defined: each conv result SHALL be clamped to 0 when negative, before pooling.
- Undefined: raw signed conv results are pooled.

Verification
REQ-026 Default parameters, all-zero frame -> 169 pool_data_vld strobes, all pool_data = 0, 13 vid_hsync pulses.
REQ-027 Default parameters, all-ones frame -> 169 outputs of 9. The first output arrives 2 cycles after pixel (3,3) is accepted.
REQ-028 Default parameters, single 1 at pixel (3,3) -> pool(0,0)=pool(0,1)=pool(1,0)=pool(1,1)=1; all other outputs 0.
REQ-029 BIAS=-5, all-zero frame -> outputs 0 with CNN_RELU_EN defined; 0xFFFFFFFB without it.
REQ-030 All-ones frame with bin_data_vld high every third cycle -> same 169 values of 9 as REQ-027. active_video spans each pooled row.
REQ-031 Reset asserted after 400 pixels, then a full all-ones frame -> exactly 169 outputs of 9, with no stale output from the aborted frame.
